// File: rtl/width_adapter_pkg.sv
// rtl/width_adapter_pkg.sv - shared types and helpers for the width adapter arbiter
// Purpose: FSM state encoding, a clog2 that never returns 0, and the default id width.
// Ports: none (package).
package width_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // $clog2(1) is 0, but an index field still needs at least one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int NREQ_DEFAULT = 4;
  localparam int ID_W         = clog2_safe(NREQ_DEFAULT);

endpackage

// File: rtl/width_adapter_arbiter_rr_pick.sv
// rtl/width_adapter_arbiter_rr_pick.sv - combinational round-robin first-valid picker
// Purpose: select the first asserted request at or after i_ptr, wrapping cyclically.
// Ports:
//   i_req  N-bit request vector
//   i_ptr  W-bit search start index (must be < N)
//   o_gnt  N-bit one-hot grant (all zero when no request)
//   o_idx  W-bit encoded index of the grant (0 when no request)
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    // First pass: indices at or after the pointer have priority.
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j] && (W'(j) >= i_ptr)) begin
        w_found  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = W'(j);
      end
    end
    // Second pass: wrapped indices below the pointer.
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j]) begin
        w_found  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/width_adapter_arbiter.sv
// rtl/width_adapter_arbiter.sv - packet round-robin arbiter in front of a width adapter
// Purpose: shares one adapter input among NREQ requesters, one whole packet at a time,
//          holding the grant until the adapter has emitted every bit of that packet.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   req_data/valid/last  requester streams (requester i at req_data[i*IW +: IW])
//   req_ready            per-requester ready
//   ad_idata/ad_ivalid   adapter input stream, ad_iready back from adapter
//   ad_ovalid/ad_oready  monitored adapter output handshake
//   gnt_valid/gnt_id     current owner tag, valid while transferring or draining
//   err                  sticky: output handshake with < OW bits pending, or pend overflow
module width_adapter_arbiter
  import width_adapter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 64,
  parameter int OW   = 32,
  parameter int CW   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ*IW-1:0]          req_data,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             req_ready,
  output logic [IW-1:0]               ad_idata,
  output logic                        ad_ivalid,
  input  logic                        ad_iready,
  input  logic                        ad_ovalid,
  input  logic                        ad_oready,
  output logic                        gnt_valid,
  output logic [clog2_safe(NREQ)-1:0] gnt_id,
  output logic                        err
);

  localparam int GW = clog2_safe(NREQ);
  // Two spare bits so the +IW step never wraps before overflow is detected.
  localparam int PW = CW + 2;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_gnt_id;
  logic            r_gnt_valid;
  logic            r_err;
  logic [CW-1:0]   r_pend;

  logic [NREQ-1:0] w_pick_gnt;
  logic [GW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_under;
  logic            w_over;
  logic            w_release;
  logic [PW-1:0]   w_pend_ext;
  logic [CW-1:0]   w_pend_nxt;
  logic [GW-1:0]   w_ptr_nxt;

  rr_pick #(
    .N (NREQ),
    .W (GW)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  assign w_pick_any = |w_pick_gnt;

  // Owner mux: data, valid and last of the granted requester.
  always_comb begin
    ad_idata    = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == r_gnt_id) begin
        ad_idata    = req_data[i*IW +: IW];
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
      end
    end
  end

  assign ad_ivalid = (r_state == XFER) && w_sel_valid;

  // Ready is a straight pass-through of the adapter so no bubble is added.
  always_comb begin
    req_ready = '0;
    if (r_state == XFER) begin
      for (int i = 0; i < NREQ; i++) begin
        if (GW'(i) == r_gnt_id) begin
          req_ready[i] = ad_iready;
        end
      end
    end
  end

  assign w_in_hs  = ad_ivalid && ad_iready;
  assign w_out_hs = ad_ovalid && ad_oready;
  assign w_under  = w_out_hs && (r_pend < CW'(OW));

  // Bits held inside the adapter. An underflowing output is flagged but not
  // subtracted, so the counter cannot wrap to a huge value.
  always_comb begin
    w_pend_ext = {2'b00, r_pend};
    if (w_in_hs) begin
      w_pend_ext = w_pend_ext + PW'(IW);
    end
    if (w_out_hs && !w_under) begin
      w_pend_ext = w_pend_ext - PW'(OW);
    end
  end

  assign w_over     = (w_pend_ext[PW-1:CW] != '0);
  assign w_pend_nxt = w_pend_ext[CW-1:0];
  assign w_ptr_nxt  = (r_gnt_id == GW'(NREQ - 1)) ? '0 : (r_gnt_id + GW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_in_hs && w_sel_last) begin
          if (w_pend_nxt == '0) begin
            w_state_nxt = IDLE;
            w_release   = 1'b1;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pend_nxt == '0) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_err       <= 1'b0;
      r_pend      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_under || w_over) begin
        r_err <= 1'b1;
      end
      if ((r_state == IDLE) && w_pick_any) begin
        r_gnt_id    <= w_pick_idx;
        r_gnt_valid <= 1'b1;
      end
      if (w_release) begin
        r_gnt_valid <= 1'b0;
        r_ptr       <= w_ptr_nxt;
      end
    end
  end

  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign err       = r_err;

endmodule

// File: doc/width_adapter_arbiter.md
Name: width_adapter_arbiter

Overview:
- Packet-level round-robin arbiter that shares one WidthAdapter input port among NREQ valid/ready requesters.
- Grants one requester per packet (terminated by req_last) and never interleaves packets.
- Holds the grant until the adapter has drained every bit of the packet, so gnt_id is a valid source tag for all adapter output beats.
- Sits directly upstream of WidthAdapter. It monitors the adapter's output handshake and does not drive it.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IW, 64, adapter input width in bits.
- OW, 32, adapter output width in bits.
- CW, 16, width of the pending-bit counter; it must hold the largest packet in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the next rising clk edge).
- req_data  in  NREQ*IW  requester data; requester i occupies slice [i*IW +: IW].
- req_valid  in  NREQ  per-requester valid.
- req_last  in  NREQ  per-requester last beat of packet; sampled only with valid&&ready.
- req_ready  out  NREQ  per-requester ready.
- ad_idata  out  IW  data to adapter idata.
- ad_ivalid  out  1  to adapter ivalid.
- ad_iready  in  1  from adapter iready.
- ad_ovalid  in  1  monitor of adapter ovalid.
- ad_oready  in  1  monitor of adapter oready.
- gnt_valid  out  1  a packet is granted or draining.
- gnt_id  out  $clog2(NREQ)  index of the current owner.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst==0 at a clk edge) sets:
  - state=IDLE, ptr=0, gnt_id=0, gnt_valid=0, err=0, pend=0.
  - req_ready=0 and ad_ivalid=0 from the following cycle.
- Reset mid-packet discards the packet. The adapter shares the same rst.
- States are IDLE, XFER and DRAIN.
- IDLE:
  - req_ready=0, ad_ivalid=0, gnt_valid=0.
  - If any req_valid is high, pick the first index at or after ptr, searching cyclically.
  - Register that index in gnt_id, set gnt_valid=1 and go to XFER on the next edge.
  - Grant latency is 1 cycle. No data is forwarded in the cycle the request is first seen.
- XFER:
  - ad_idata = req_data[g], ad_ivalid = req_valid[g], req_ready[g] = ad_iready, all other req_ready=0.
  - The valid-to-ready path is combinational through the mux and adds no bubble.
  - ad_idata is don't-care when ad_ivalid=0.
- Pending counter pend:
  - On each edge, pend += IW if ad_ivalid&&ad_iready.
  - On each edge, pend -= OW if ad_ovalid&&ad_oready.
  - Both in the same cycle apply the net value.
- Packet end:
  - An accepted beat with req_last[g]=1 moves to DRAIN.
  - If the updated pend is 0, go to IDLE directly instead.
- DRAIN:
  - req_ready all 0, ad_ivalid=0. gnt_valid and gnt_id are held.
  - When the updated pend reaches 0, go to IDLE and set ptr=(g+1) mod NREQ.
- Leaving XFER/DRAIN to IDLE clears gnt_valid on the same edge. A new grant needs at least one IDLE cycle, so packets are spaced by 1 cycle.
- Packet alignment: packet bits must be a multiple of OW. Otherwise pend never reaches 0 and the arbiter stalls in DRAIN by design; the bench treats this as a stimulus bug.
- err is set (sticky until reset) on any of:
  - an adapter output handshake while pend<OW, including in IDLE;
  - pend overflowing CW bits.
- Fairness: a requester that holds valid continuously is granted within NREQ-1 packets.
- A requester that drops req_valid mid-packet simply stalls the transfer. The grant is kept and there is no timeout.

Decomposition:
- Shared package width_adapter_pkg holds:
  - the state enum (IDLE/XFER/DRAIN);
  - the function clog2_safe;
  - the constant ID_W = clog2_safe(NREQ).
- One sub-module, rr_pick: combinational round-robin "first valid at or after ptr" over NREQ bits.
  - Outputs a one-hot grant plus the encoded index.
  - Reused by later shared-resource blocks.

Test Plan:
All scenarios use IW=64, OW=32, NREQ=4 with a real WidthAdapter attached.
1. Single packet: requester 2 sends 3 beats, last on beat 3, oready=1.
   -> gnt_id=2 one cycle after valid; 6 output words in order, tagged 2.
   -> IDLE after the final output handshake; ptr=3.
2. All 4 requesters valid continuously with 1-beat packets.
   -> Grant order 0,1,2,3,0; gnt_valid low exactly 1 cycle between packets.
3. Backpressure: oready random 50%, requester 1 sends 8 beats.
   -> The next grant does not occur until 16 output words complete.
   -> Output data equals input data split high-first; err=0.
4. Simultaneous in/out: pend=32 and an input and an output handshake occur in the same cycle.
   -> pend=64 on the next cycle.
5. Reset mid-XFER: rst=0 for 1 cycle after 2 beats.
   -> Next cycle gnt_valid=0, req_ready=0, ptr=0, pend=0.
   -> A fresh packet from requester 3 completes correctly.
6. Spurious output handshake in IDLE (ad_ovalid=1, ad_oready=1 forced).
   -> err=1 next cycle and stays 1 until rst=0.
